// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack bus and fetch-to-decode instruction stream.
// The master modport is the fetch stage; the slave modport is memory plus decode.
interface fetch_stage_if #(
    parameter int unsigned W_ADDR = 32
);
    logic              imem_req;
    logic [W_ADDR-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [W_ADDR-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues req/ack fetches and buffers
// {instruction, pc} pairs toward decode, with redirect/flush of stale fetches.
module fetch_stage #(
    parameter int unsigned       W_ADDR     = 32,
    parameter logic [W_ADDR-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2,
    parameter int unsigned       W_IMM      = 16,
    parameter int unsigned       W_JADDR    = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [1:0]         pc_src,
    input  logic               branch_taken,
    input  logic [W_ADDR-1:0]  redirect_base,
    input  logic [W_JADDR-1:0] jump_addr,
    input  logic [W_IMM-1:0]   imm,
    input  logic [W_ADDR-1:0]  reg_addr,
    fetch_stage_if.master      bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {SrcNext, SrcJump, SrcBrch, SrcRegf} pc_src_e;
    typedef enum logic {StFetch, StDrain} state_e;

    state_e             state_q, state_d;
    logic [W_ADDR-1:0]  pc_q, pc_d;
    logic [W_ADDR-1:0]  pend_q, pend_d;
    logic               rst_hold_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [31:0]        mem_inst [FIFO_DEPTH];
    logic [W_ADDR-1:0]  mem_pc [FIFO_DEPTH];
    logic [31:0]        inst_hold_q;
    logic [W_ADDR-1:0]  pc_hold_q;

    logic [W_ADDR-1:0]  seq;
    logic [W_ADDR-1:0]  imm_ext;
    logic [W_ADDR-1:0]  target;
    logic               redirect_eff;
    logic               ack_fire;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        seq          = redirect_base + W_ADDR'(4);
        imm_ext      = {{(W_ADDR - W_IMM){imm[W_IMM-1]}}, imm};
        target       = '0;
        redirect_eff = 1'b0;
        if (redirect_valid) begin
            case (pc_src)
                SrcJump: begin
                    target       = (seq & ({W_ADDR{1'b1}} << (W_JADDR + 2)))
                                 | (W_ADDR'(jump_addr) << 2);
                    redirect_eff = 1'b1;
                end
                SrcBrch: begin
                    target       = seq + (imm_ext << 2);
                    redirect_eff = branch_taken;
                end
                SrcRegf: begin
                    target       = {reg_addr[W_ADDR-1:2], 2'b00};
                    redirect_eff = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Request is gated for one cycle after any reset edge; the space check only
    // applies while fetching, since draining always owns an issued request.
    assign bus.imem_req   = !rst_hold_q && ((state_q == StDrain) || (count_q < DEPTH_C));
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = bus.inst_valid ? mem_inst[rd_ptr_q] : inst_hold_q;
    assign bus.inst_pc    = bus.inst_valid ? mem_pc[rd_ptr_q] : pc_hold_q;

    assign ack_fire = bus.imem_req && bus.imem_ack;
    assign push     = (state_q == StFetch) && ack_fire && !redirect_eff;
    assign pop      = bus.inst_valid && bus.inst_ready && !redirect_eff;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        unique case (state_q)
            StFetch: begin
                if (redirect_eff) begin
                    // An issued request cannot be withdrawn: keep its address and drain it.
                    if (bus.imem_req && !bus.imem_ack) begin
                        state_d = StDrain;
                        pend_d  = target;
                    end else begin
                        pc_d = target;
                    end
                end else if (ack_fire) begin
                    pc_d = pc_q + W_ADDR'(4);
                end
            end
            StDrain: begin
                if (ack_fire) begin
                    pc_d    = redirect_eff ? target : pend_q;
                    state_d = StFetch;
                end else if (redirect_eff) begin
                    pend_d = target;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (redirect_eff) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            pend_q     <= RESET_PC;
            rst_hold_q <= 1'b1;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            rst_hold_q <= 1'b0;
            count_q    <= count_d;
            if (redirect_eff) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr_q] <= bus.imem_rdata;
            mem_pc[wr_ptr_q]   <= pc_q;
        end
        if (bus.inst_valid) begin
            inst_hold_q <= bus.inst;
            pc_hold_q   <= bus.inst_pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based behavioural model,
// preceded by directed scenarios with hand-computed addresses.
module tb_fetch_stage;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h100;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] redirect_base;
    logic [25:0] jump_addr;
    logic [15:0] imm;
    logic [31:0] reg_addr;

    fetch_stage_if #(.W_ADDR(32)) bus ();

    fetch_stage #(
        .W_ADDR    (32),
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH),
        .W_IMM     (16),
        .W_JADDR   (26)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .pc_src        (pc_src),
        .branch_taken  (branch_taken),
        .redirect_base (redirect_base),
        .jump_addr     (jump_addr),
        .imm           (imm),
        .reg_addr      (reg_addr),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Staged stimulus, applied at the next negedge by cycle().
    logic        s_rst = 1'b1, s_rv = 1'b0, s_taken = 1'b0, s_ack = 1'b0, s_ready = 1'b0;
    logic [1:0]  s_src = 2'b00;
    logic [31:0] s_base = '0, s_ra = '0;
    logic [25:0] s_ja = '0;
    logic [15:0] s_imm = '0;

    // Reference model state.
    ent_t        m_q[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_pend = '0;
    bit          m_drain = 1'b0;
    bit          m_hold = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic model_step(input bit req);
        logic [31:0] seq, tgt;
        bit          eff, acked;
        if (s_rst) begin
            m_pc    = RST_PC;
            m_drain = 1'b0;
            m_hold  = 1'b1;
            m_q.delete();
            return;
        end
        m_hold = 1'b0;
        seq    = s_base + 32'd4;
        tgt    = '0;
        eff    = 1'b0;
        case (s_src)
            2'b01: begin eff = 1'b1; tgt = (seq & ~32'h0FFF_FFFF) | ({6'd0, s_ja} * 4); end
            2'b10: begin eff = s_taken; tgt = seq + 32'(int'($signed(s_imm)) * 4); end
            2'b11: begin eff = 1'b1; tgt = s_ra & ~32'd3; end
            default: eff = 1'b0;
        endcase
        eff   = eff && s_rv;
        acked = req && s_ack;
        if (eff) m_q.delete();
        else if (m_q.size() != 0 && s_ready) void'(m_q.pop_front());
        if (m_drain) begin
            if (acked) begin
                m_pc    = eff ? tgt : m_pend;
                m_drain = 1'b0;
            end else if (eff) begin
                m_pend = tgt;
            end
        end else if (eff) begin
            if (req && !s_ack) begin
                m_drain = 1'b1;
                m_pend  = tgt;
            end else begin
                m_pc = tgt;
            end
        end else if (acked) begin
            m_q.push_back('{ins: mem_word(m_pc), pc: m_pc});
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic cycle();
        bit m_req;
        @(negedge clk);
        m_req = !m_hold && (m_drain || m_q.size() < DEPTH);
        check_val("imem_req", {31'd0, bus.imem_req}, {31'd0, m_req});
        if (m_req) check_val("imem_addr", bus.imem_addr, m_pc);
        check_val("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            check_val("inst", bus.inst, m_q[0].ins);
            check_val("inst_pc", bus.inst_pc, m_q[0].pc);
        end
        rst            = s_rst;
        redirect_valid = s_rv;
        pc_src         = s_src;
        branch_taken   = s_taken;
        redirect_base  = s_base;
        jump_addr      = s_ja;
        imm            = s_imm;
        reg_addr       = s_ra;
        bus.imem_ack   = s_ack;
        bus.imem_rdata = mem_word(m_pc);
        bus.inst_ready = s_ready;
        model_step(m_req);
        @(posedge clk);
    endtask

    task automatic redir(input logic [1:0] src, input logic [31:0] base, input logic [31:0] ra);
        s_rv   = 1'b1;
        s_src  = src;
        s_base = base;
        s_ra   = ra;
    endtask

    int ready_bias;

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; pc_src = 2'b00; branch_taken = 1'b0;
        redirect_base = '0; jump_addr = '0; imm = '0; reg_addr = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Sequential fetch from RESET_PC with zero-wait memory.
        cycle();
        s_rst = 1'b0; s_ack = 1'b1; s_ready = 1'b1;
        cycle(); #1;
        check_val("t1_req_first", {31'd0, bus.imem_req}, 32'd1);
        check_val("t1_addr0", bus.imem_addr, 32'h100);
        check_val("t1_valid_first", {31'd0, bus.inst_valid}, 32'd0);
        cycle(); #1;
        check_val("t1_addr1", bus.imem_addr, 32'h104);
        check_val("t1_pc0", bus.inst_pc, 32'h100);
        cycle(); #1;
        check_val("t1_addr2", bus.imem_addr, 32'h108);
        check_val("t1_pc1", bus.inst_pc, 32'h104);

        // Back-pressure fills the buffer, then drains in order.
        s_rst = 1'b1; cycle();
        s_rst = 1'b0; s_ready = 1'b0; cycle();
        cycle(); cycle(); #1;
        check_val("t2_full_req", {31'd0, bus.imem_req}, 32'd0);
        check_val("t2_head", bus.inst_pc, 32'h100);
        cycle(); #1;
        check_val("t2_still_full", {31'd0, bus.imem_req}, 32'd0);
        s_ready = 1'b1; cycle(); #1;
        check_val("t2_head_after_pop", bus.inst_pc, 32'h104);
        check_val("t2_resume_addr", bus.imem_addr, 32'h108);

        // Jump and branch redirects.
        redir(2'b01, 32'h0040_0010, '0); s_ja = 26'h010_0040;
        cycle(); #1;
        check_val("t3_jump_addr", bus.imem_addr, 32'h0040_0100);
        check_val("t3_jump_flush", {31'd0, bus.inst_valid}, 32'd0);
        redir(2'b10, 32'h200, '0); s_imm = 16'hFFFE; s_taken = 1'b1;
        cycle(); #1;
        check_val("t3_brch_taken", bus.imem_addr, 32'h1FC);
        s_taken = 1'b0;
        cycle(); #1;
        check_val("t3_brch_nt_addr", bus.imem_addr, 32'h200);
        check_val("t3_brch_nt_head", bus.inst_pc, 32'h1FC);
        s_rv = 1'b0;

        // Register redirect while a slow request is outstanding.
        s_ack = 1'b0;
        redir(2'b11, '0, 32'h1003);
        cycle(); #1;
        s_rv = 1'b0;
        check_val("t4_addr_stable0", bus.imem_addr, 32'h200);
        check_val("t4_req_stable", {31'd0, bus.imem_req}, 32'd1);
        cycle(); #1;
        check_val("t4_addr_stable1", bus.imem_addr, 32'h200);
        s_ack = 1'b1; cycle(); #1;
        check_val("t4_next_addr", bus.imem_addr, 32'h1000);
        check_val("t4_dropped", {31'd0, bus.inst_valid}, 32'd0);

        // Repeated redirects while draining; redirect coincident with ack.
        s_ack = 1'b0;
        redir(2'b11, '0, 32'h2000); cycle();
        redir(2'b11, '0, 32'h300);  cycle();
        redir(2'b11, '0, 32'h400);  cycle();
        s_rv = 1'b0; s_ack = 1'b1; cycle(); #1;
        check_val("t5_drain_last", bus.imem_addr, 32'h400);
        redir(2'b11, '0, 32'h500); cycle(); #1;
        s_rv = 1'b0;
        check_val("t5_ack_redirect", bus.imem_addr, 32'h500);
        check_val("t5_ack_dropped", {31'd0, bus.inst_valid}, 32'd0);

        // Reset during an outstanding request; ack arrives late.
        s_ack = 1'b0; cycle();
        s_rst = 1'b1; cycle(); #1;
        check_val("t6_req_low", {31'd0, bus.imem_req}, 32'd0);
        check_val("t6_empty", {31'd0, bus.inst_valid}, 32'd0);
        s_rst = 1'b0; s_ack = 1'b1; cycle(); #1;
        check_val("t6_restart", bus.imem_addr, RST_PC);
        check_val("t6_late_ack", {31'd0, bus.inst_valid}, 32'd0);
        cycle(); #1;
        check_val("t6_first_inst", bus.inst_pc, RST_PC);

        // Random traffic against the model.
        ready_bias = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) ready_bias = $urandom_range(0, 3);
            s_rst   = ($urandom_range(0, 99) == 0);
            s_rv    = ($urandom_range(0, 4) == 0);
            s_src   = 2'($urandom);
            s_taken = 1'($urandom);
            s_base  = $urandom & ~32'd3;
            s_ja    = 26'($urandom);
            s_imm   = 16'($urandom);
            s_ra    = $urandom;
            s_ack   = ($urandom_range(0, 2) != 0);
            s_ready = ($urandom_range(0, 3) >= ready_bias);
            cycle();
        end
        s_rst = 1'b0; s_rv = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Parametrised instruction-fetch front end. Owns the program counter and issues word-aligned requests to instruction memory over a req/ack handshake. Buffers returned instructions, tagged with their PCs, in a small FIFO toward decode. Supports sequential, jump, branch and register redirects, with flush of buffered and in-flight instructions.

Parameters:
W_ADDR, 32, PC / memory address width (>= 28)
RESET_PC, 0, PC loaded on reset (word aligned)
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >= 1)
W_IMM, 16, branch immediate width
W_JADDR, 26, jump target field width

Ports:
clk  in  1  clock
rst  in  1  reset
redirect_valid  in  1  control-flow redirect this cycle
pc_src  in  2  00 NEXT, 01 JUMP, 10 BRCH, 11 REGF
branch_taken  in  1  branch condition result (BRCH only)
redirect_base  in  W_ADDR  PC of the redirecting instruction
jump_addr  in  W_JADDR  jump field
imm  in  W_IMM  branch offset in words, signed
reg_addr  in  W_ADDR  register target
imem_req  out  1  fetch request
imem_addr  out  W_ADDR  fetch address
imem_ack  in  1  request complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
inst_valid  out  1  FIFO head valid
inst  out  32  FIFO head instruction
inst_pc  out  W_ADDR  FIFO head PC
inst_ready  in  1  decode accepts head (pop when valid & ready)

Behaviour:
- Reset is synchronous and active-high on rst, sampled at posedge clk. One clock, clk.
- Reset values: pc = RESET_PC, imem_req = 0, FIFO empty, inst_valid = 0, state = FETCH.
- Register rst beyond the above to force state = FETCH and clear discard marks. rst mid-request abandons the request. imem_req = 0 in the cycle after the reset edge.
- Redirect target, computed from redirect_base, with seq = redirect_base + 4:
  - JUMP: {seq[W_ADDR-1:W_JADDR+2], jump_addr, 2'b00}
  - BRCH with branch_taken = 1: seq + (sign-extended imm << 2), wrapping modulo 2^W_ADDR
  - BRCH with branch_taken = 0: no redirect; ignored entirely, no flush
  - REGF: reg_addr with bits [1:0] forced to 0
  - NEXT: no redirect; ignored
- An effective redirect flushes the FIFO in the same edge; a simultaneous pop is void. pc then takes the target.
- FSM states:
  - FETCH: imem_req = (count < FIFO_DEPTH); imem_addr = pc. Once imem_req is asserted, imem_req and imem_addr hold stable until imem_ack.
  - On ack in FETCH: push {imem_rdata, pc}, then pc += 4.
  - On ack in the same cycle as an effective redirect: data dropped, pc = target, stay FETCH.
  - Effective redirect while req is high without ack: pc_pending = target, go to DRAIN. The request stays asserted with its original address.
  - DRAIN: on ack, discard data, pc = pc_pending, go to FETCH. A further redirect in DRAIN overwrites pc_pending. A redirect on the ack cycle wins: its target is used.
  - Effective redirect in FETCH with req low: pc = target immediately.
- Count changes only on push or pop, so the space check cannot revoke an asserted request.
- Latency: the first imem_req is high in the first cycle after reset release. Ack in cycle N gives inst_valid in N+1. With zero-wait memory (ack in the same cycle as req) and inst_ready = 1, throughput is 1 instruction/cycle.
- FIFO:
  - Order preserved.
  - Full: imem_req low until a pop.
  - Empty: inst_valid = 0; inst and inst_pc hold their last values.
  - Push and pop in the same cycle when full is impossible (no req when full). When not full, both proceed and count is unchanged.
- PC increments wrap modulo 2^W_ADDR.

Test Plan:
1. RESET_PC = 0x100, ack every cycle, inst_ready = 1 -> imem_addr 0x100, 0x104, 0x108. inst_pc matches one cycle after each ack; inst_valid = 0 during reset and in the first cycle after it.
2. inst_ready = 0, FIFO_DEPTH = 2 -> exactly two acks accepted, then imem_req = 0. Raise inst_ready -> pops 0x100 then 0x104, and fetch resumes at 0x108.
3. JUMP, base 0x00400010, jump_addr 0x0100040 -> next imem_addr 0x00400100, FIFO emptied. BRCH, base 0x200, imm 0xFFFE, taken -> 0x1FC. Same inputs, not taken -> sequence continues, FIFO untouched.
4. Ack delayed 3 cycles; REGF redirect to 0x1003 in wait cycle 1 -> address stays stable until ack. Acked word is never presented. Next request is at 0x1000.
5. Redirect in DRAIN to 0x300, then another to 0x400 before ack -> next request at 0x400. Redirect coincident with ack in FETCH -> word dropped, next request at target.
6. rst asserted mid-wait -> imem_req = 0 the cycle after the edge, FIFO empty. After release, fetch restarts at RESET_PC and the late ack is ignored.
